// File: rtl/instr_dcd_pkg.sv
// rtl/instr_dcd_pkg.sv - shared command layout, FSM encoding and register map for instr_dcd
package instr_dcd_pkg;

  // Command byte layout
  localparam int RW_BIT   = 7;
  localparam int HL_BIT   = 6;
  localparam int ADDR_MSB = 5;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  // Decoder FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DATA = 2'd1,
    ST_DO_WRITE  = 2'd2
  } state_e;

  // Fields pulled out of a command byte
  typedef struct packed {
    logic              rw;
    logic              hi_lo;
    logic [ADDR_W-1:0] addr;
  } cmd_t;

  // Register map seen by the register block behind the decoder
  localparam logic [ADDR_W-1:0] REG_ID      = 6'h00;
  localparam logic [ADDR_W-1:0] REG_CTRL    = 6'h01;
  localparam logic [ADDR_W-1:0] REG_STATUS  = 6'h02;
  localparam logic [ADDR_W-1:0] REG_IRQ_EN  = 6'h03;
  localparam logic [ADDR_W-1:0] REG_IRQ_ST  = 6'h04;
  localparam logic [ADDR_W-1:0] REG_DATA0   = 6'h05;
  localparam logic [ADDR_W-1:0] REG_DATA1   = 6'h06;
  localparam logic [ADDR_W-1:0] REG_SCRATCH = 6'h3F;

  // Split a received command byte into its fields
  function automatic cmd_t decode_cmd(input logic [7:0] b);
    cmd_t c;
    c.rw    = b[RW_BIT];
    c.hi_lo = b[HL_BIT];
    c.addr  = b[ADDR_MSB:ADDR_LSB];
    return c;
  endfunction

endpackage

// File: rtl/instr_dcd.sv
// rtl/instr_dcd.sv - two-byte SPI frame decoder driving register read/write strobes
module instr_dcd
  import instr_dcd_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_sync,
  input  logic [7:0]        data_in,
  output logic [7:0]        data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  output logic              hi_lo,
  input  logic [7:0]        data_read,
  output logic [7:0]        data_write,
  output logic              timeout_err
);

  // A zero TIMEOUT still needs a one-bit counter so the logic stays well formed
  localparam int              CNT_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic             TO_EN     = (TIMEOUT != 0);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic              hi_lo_q, hi_lo_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_write_q, data_write_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              read_q, read_d;
  logic              timeout_err_q, timeout_err_d;

  cmd_t              cmd;
  logic [CNT_W-1:0]  cnt_inc;

  // Next-state, latch and strobe decisions for the frame decoder
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rw_d          = rw_q;
    hi_lo_d       = hi_lo_q;
    addr_d        = addr_q;
    data_write_d  = data_write_q;
    read_d        = 1'b0;
    timeout_err_d = 1'b0;
    cmd           = decode_cmd(data_in);
    // Saturating increment so a disabled or oversized wait never wraps
    cnt_inc       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (byte_sync) begin
          rw_d    = cmd.rw;
          hi_lo_d = cmd.hi_lo;
          addr_d  = cmd.addr;
          // Reads are issued right away; the second byte is only a dummy
          read_d  = ~cmd.rw;
          cnt_d   = '0;
          state_d = ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: begin
        if (byte_sync) begin
          // An arriving byte always beats a timeout in the same cycle
          if (rw_q) begin
            data_write_d = data_in;
            state_d      = ST_DO_WRITE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_inc;
          if (TO_EN && (cnt_inc == CNT_LIMIT)) begin
            timeout_err_d = 1'b1;
            state_d       = ST_IDLE;
          end
        end
      end
      ST_DO_WRITE: begin
        // Bytes arriving here are dropped; the write strobe lasts one cycle
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read data is captured at the end of the cycle the read strobe is high
  always_comb begin
    data_out_d = data_out_q;
    if (read_q) begin
      data_out_d = data_read;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rw_q          <= 1'b0;
      hi_lo_q       <= 1'b0;
      addr_q        <= '0;
      data_write_q  <= '0;
      data_out_q    <= '0;
      read_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rw_q          <= rw_d;
      hi_lo_q       <= hi_lo_d;
      addr_q        <= addr_d;
      data_write_q  <= data_write_d;
      data_out_q    <= data_out_d;
      read_q        <= read_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign data_out    = data_out_q;
  assign read        = read_q;
  assign write       = (state_q == ST_DO_WRITE);
  assign addr        = addr_q;
  assign hi_lo       = hi_lo_q;
  assign data_write  = data_write_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/instr_dcd.md
INSTR_DCD -- requirements
Module: instr_dcd

Interface
REQ-001 Parameter TIMEOUT, default 255: number of clk cycles the block waits for the second byte of a frame before aborting; a value of 0 disables the timeout.
REQ-002 clk  input  1  the single clock for the whole block.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 byte_sync  input  1  one-cycle strobe from the SPI bridge; data_in is valid in that cycle.
REQ-005 data_in  input  8  byte received from the SPI master.
REQ-006 data_out  output  8  byte returned to the bridge; the bridge samples it at the start of the next transaction.
REQ-007 read  output  1  one-cycle register-read strobe.
REQ-008 write  output  1  one-cycle register-write strobe.
REQ-009 addr  output  6  register address.
REQ-010 hi_lo  output  1  register byte lane: 1 selects the high byte, 0 the low byte.
REQ-011 data_read  input  8  register read data; combinational, valid in the same cycle that read is high.
REQ-012 data_write  output  8  register write data; valid while write is high.
REQ-013 timeout_err  output  1  one-cycle pulse when a frame is aborted by timeout.

Function
REQ-014 Frame format: command byte followed by one data byte; the data byte is a dummy for reads.
REQ-015 Command byte decode: bit7 = rw (1 = write, 0 = read); bit6 = hi_lo; bits5:0 = addr.
REQ-016 FSM states: IDLE, WAIT_DATA, DO_WRITE; the block leaves reset in IDLE.
REQ-017 IDLE, byte_sync high: latch rw, hi_lo and addr on that edge, then go to WAIT_DATA.
REQ-018 Read command accepted (call the accepting cycle T): read high in cycle T+1 with addr and hi_lo valid; data_read captured into data_out at the end of T+1; data_out shows the new value from T+2.
REQ-019 data_out holds its value until the next read, regardless of any writes or timeouts in between.
REQ-020 WAIT_DATA, byte_sync high, write frame: latch data_in into data_write, go to DO_WRITE.
REQ-021 DO_WRITE: write high for exactly one cycle, with addr, hi_lo and data_write stable; then go to IDLE.
REQ-022 WAIT_DATA, byte_sync high, read frame: discard data_in, go to IDLE; read and write both stay low.
REQ-023 Timeout counter: cleared on entry to WAIT_DATA; increments every cycle in WAIT_DATA while byte_sync is low.
REQ-024 Timeout counter width: clog2(TIMEOUT+1) bits; the counter saturates and never wraps.
REQ-025 Timeout: when the counter reaches TIMEOUT in WAIT_DATA, pulse timeout_err for one cycle and go to IDLE; no strobe is issued.
REQ-026 byte_sync and the timeout condition in the same cycle: byte_sync wins and the frame completes normally.
REQ-027 TIMEOUT = 0: the block never times out and timeout_err stays 0.
REQ-028 byte_sync while in DO_WRITE: the byte is ignored.
REQ-029 read and write are never high in the same cycle.
REQ-030 addr, hi_lo and data_write hold their last latched values between frames.

Reset
REQ-031 rst high on any clk edge: FSM to IDLE and timeout counter to 0.
REQ-032 rst high on any clk edge: data_out, data_write and addr to 0; hi_lo, read, write and timeout_err to 0.
REQ-033 Reset mid-frame: any pending write is dropped; the first byte_sync after reset is decoded as a command byte.

Structure
REQ-034 A shared package holds: command bit positions (RW_BIT = 7, HL_BIT = 6, ADDR_MSB = 5, ADDR_LSB = 0), the FSM state encoding, and the register address constants used by the register block.
REQ-035 The block is a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-036 Write frame: bytes 0x85 then 0x3C -> write high for one cycle, one cycle after the second byte_sync, with addr = 0x05, hi_lo = 0, data_write = 0x3C.
REQ-037 Read frame: byte 0x4A with data_read = 0xA7 -> read high in T+1 with addr = 0x0A, hi_lo = 1; data_out = 0xA7 from T+2; dummy byte 0xFF -> IDLE, write never asserted.
REQ-038 Timeout (TIMEOUT = 16): byte 0x81, then no byte_sync -> timeout_err pulses 16 cycles after entering WAIT_DATA, no write; next byte 0x02 -> read of addr 0x02.
REQ-039 Race (TIMEOUT = 16): byte 0x81, then byte 0x11 with byte_sync arriving in the cycle the counter hits 16 -> write to addr 0x01 with data 0x11, timeout_err stays 0.
REQ-040 Reset mid-frame: byte 0x81, rst high for 1 cycle, then byte 0x55 -> 0x55 decoded as a read of addr 0x15 with hi_lo = 1; data_out = 0 before that read completes.
